// File: rtl/mem_responder.sv
// mem_responder: word-organised synchronous memory behind a valid/ready
// request channel and a valid/ready response channel. One request is in
// flight at a time: IDLE accepts, ACCESS performs the array operation,
// RESP presents the result until the initiator takes it.
//
// Optional feature macro: MEM_RESPONDER_CLEAR_EN
//   Defined   -> after reset the FSM sits in CLEAR, zeroing one word per
//                cycle (DEPTH cycles), before accepting requests.
//   Undefined -> IDLE immediately after reset; unwritten words are undefined.
//
// Ports:
//   clk, rst               clock, async active-high reset (control state only)
//   req_valid/req_ready    request handshake
//   WR, address, Din       request: 1=write/0=read, byte address, write data
//   rsp_valid/rsp_ready    response handshake
//   Do, rsp_err            response: read data or echoed write data, error flag
module mem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              WR,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] Din,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] Do,
  output logic              rsp_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {CLEAR, IDLE, ACCESS, RESP} state_t;

`ifdef MEM_RESPONDER_CLEAR_EN
  localparam state_t RST_ST = CLEAR;
`else
  localparam state_t RST_ST = IDLE;
`endif

  state_t state;

  // Latched request
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;

  // Storage has no reset; only control state is reset.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-3:0] word;
  logic [IW-1:0]     widx;
  logic              err;

  assign word = addr_q[ADDR_W-1:2];
  // DEPTH <= 2^(ADDR_W-2) guarantees IW <= ADDR_W-2.
  assign widx = addr_q[IW+1:2];
  // One extra bit so DEPTH == 2^(ADDR_W-2) fits in the comparison.
  assign err  = (addr_q[1:0] != 2'b00) ||
                ({1'b0, word} >= (ADDR_W-1)'(DEPTH));

  // Gated by rst so nothing is decoded while reset is held.
  assign req_ready = (state == IDLE) && !rst;

`ifdef MEM_RESPONDER_CLEAR_EN
  logic [IW-1:0] clr_cnt;
`endif

  // Array write port: request writes in ACCESS, zero-fill in CLEAR.
  logic              mem_we;
  logic [IW-1:0]     mem_wa;
  logic [DATA_W-1:0] mem_wd;

  always_comb begin
    mem_we = 1'b0;
    mem_wa = widx;
    mem_wd = din_q;
    if (!rst) begin
      if (state == ACCESS && wr_q && !err) begin
        mem_we = 1'b1;
      end
`ifdef MEM_RESPONDER_CLEAR_EN
      else if (state == CLEAR) begin
        mem_we = 1'b1;
        mem_wa = clr_cnt;
        mem_wd = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RST_ST;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      Do        <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
`ifdef MEM_RESPONDER_CLEAR_EN
      clr_cnt   <= '0;
`endif
    end else begin
      case (state)
        CLEAR: begin
`ifdef MEM_RESPONDER_CLEAR_EN
          if (clr_cnt == IW'(DEPTH - 1)) state <= IDLE;
          else clr_cnt <= clr_cnt + 1'b1;
`else
          state <= IDLE;
`endif
        end
        IDLE: begin
          if (req_valid) begin
            wr_q   <= WR;
            addr_q <= address;
            din_q  <= Din;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err;
          if (err)       Do <= '0;
          else if (wr_q) Do <= din_q;
          else           Do <= mem[widx];
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int D  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          WR = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] Din = '0;
  logic          rsp_ready = 1'b0;
  logic          req_ready, rsp_valid, rsp_err;
  logic [DW-1:0] Do;

  int checks = 0;
  int failures = 0;

  // Reference model: expected word contents and whether each is defined.
  logic [DW-1:0] mdl [D];
  bit            known [D];

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .WR(WR), .address(address), .Din(Din),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .Do(Do), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected result of one request, applied to the model.
  task automatic model(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output logic eerr, output logic [DW-1:0] edo, output bit dknown);
    int w;
    w = int'(a) / 4;
    eerr = (a % 4 != 0) || (w >= D);
    dknown = 1'b1;
    if (eerr) edo = '0;
    else if (wr) begin
      mdl[w] = d; known[w] = 1'b1; edo = d;
    end else begin
      edo = mdl[w]; dknown = known[w];
    end
  endtask

  // Called at a negedge: asserts reset, checks outputs, releases it and
  // measures how many cycles until the block accepts requests.
  task automatic do_reset();
    int n;
    int exp_n;
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_Do", Do, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
`ifdef MEM_RESPONDER_CLEAR_EN
    exp_n = D;
    for (int i = 0; i < D; i++) begin mdl[i] = '0; known[i] = 1'b1; end
`else
    exp_n = 0;
`endif
    #1;
    n = 0;
    while (!req_ready && n < D + 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("ready_after_rst_cycles", n, exp_n);
    @(negedge clk);
  endtask

  // Called at a negedge: one full request/response with `hold` cycles of
  // response backpressure, during which a stray write request is presented.
  task automatic transact(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int hold);
    logic          eerr;
    logic [DW-1:0] edo;
    bit            dknown;
    int            n;
    logic [DW-1:0] held;
    req_valid = 1'b1; WR = wr; address = a; Din = d; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_wait", req_ready, 1);
    @(negedge clk);                       // handshake edge passed -> ACCESS
    req_valid = 1'b0;
    model(wr, a, d, eerr, edo, dknown);
    chk("access_rsp_valid", rsp_valid, 0);
    chk("access_req_ready", req_ready, 0);
    @(negedge clk);                       // one more edge -> RESP
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, eerr);
    if (dknown) chk("rsp_Do", Do, edo);
    held = Do;
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        req_valid = 1'b1; WR = 1'b1; address = '0; Din = 32'hBAD0BAD0;
      end
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_Do", Do, held);
      chk("stall_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_req_ready", req_ready, 1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] a;
    int kind;
    int w;
    for (int i = 0; i < D; i++) begin mdl[i] = '0; known[i] = 1'b0; end

    @(negedge clk);
    do_reset();

    // Write / readback
    transact(1'b1, 8'd0, 32'd128, 0);
    transact(1'b1, 8'd4, 32'd4096, 0);
    transact(1'b0, 8'd0, 32'd0, 0);
    transact(1'b0, 8'd4, 32'd0, 0);

    // Errors: misaligned read, out-of-range write, word 0 untouched
    transact(1'b0, 8'd2, 32'd0, 0);
    transact(1'b1, 8'd252, 32'h12345678, 0);
    transact(1'b0, 8'd0, 32'd0, 0);

    // Backpressure with a stray request presented while busy
    transact(1'b0, 8'd4, 32'd0, 5);
    transact(1'b0, 8'd0, 32'd0, 0);

    // Reset while in ACCESS: the write must not commit
    req_valid = 1'b1; WR = 1'b1; address = 8'd0; Din = 32'hDEADBEEF;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    chk("rstacc_req_ready", req_ready, 1);
    @(negedge clk);
    do_reset();
    transact(1'b0, 8'd0, 32'd0, 0);

    // Randomised traffic against the model
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = AW'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else if (kind == 1) a = AW'($urandom_range(D, 63) * 4);
      else                a = AW'($urandom_range(0, D - 1) * 4);
      transact(1'(($urandom_range(0, 1))), a, DW'($urandom), $urandom_range(0, 3));
    end

`ifdef MEM_RESPONDER_CLEAR_EN
    // After a clearing reset, word 1 reads 0
    do_reset();
    transact(1'b0, 8'd4, 32'd0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound
  initial begin
    #500000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
